uart_tx_fifo: RTL

Parametrised UART transmitter with configurable frame format, an input FIFO, and a valid/ready write port. It replaces the single-byte, edge-triggered transmitter in the serial I/O path. Host logic pushes bytes at Clk rate. The block serialises them LSB-first on `Tx`, pacing each bit by a Clk-synchronous oversampling tick from the shared baud generator. Frame format (data bits, parity, stop bits) is selectable at run time and latched per frame.

---
 rtl/uart_tx_fifo.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Bits are paced by an oversampling tick, and the
// frame format (data bits, parity, stop bits) is latched when each frame starts.
module uart_tx_fifo #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_AW    = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               tick_i,
   input  logic [3:0]         nbits_i,
   input  logic [1:0]         parity_i,
   input  logic               stop_bits_i,
   input  logic [7:0]         tx_data_i,
   input  logic               tx_valid_i,
   output logic               tx_ready_o,
   output logic               tx_o,
   output logic               tx_busy_o,
   output logic               tx_done_o,
   output logic [FIFO_AW:0]   fifo_count_o
);

   localparam int unsigned        Depth     = 2 ** FIFO_AW;
   localparam int unsigned        TickW     = $clog2(OVERSAMPLE);
   localparam logic [TickW-1:0]   TickLast  = TickW'(OVERSAMPLE - 1);
   localparam logic [TickW-1:0]   TickOne   = TickW'(1);
   localparam logic [FIFO_AW:0]   CountFull = (FIFO_AW + 1)'(Depth);
   localparam logic [FIFO_AW:0]   CountOne  = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PtrOne    = FIFO_AW'(1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e             state_q, state_d;
   logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [7:0]         shift_q, shift_d;
   logic [2:0]         nbits_q, nbits_d;
   logic               par_en_q, par_en_d;
   logic               par_odd_q, par_odd_d;
   logic               stop2_q, stop2_d;
   logic               par_acc_q, par_acc_d;
   logic               tx_q, tx_d;
   logic               done_q, done_d;
   logic [FIFO_AW-1:0] wptr_q, wptr_d;
   logic [FIFO_AW-1:0] rptr_q, rptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic [7:0]         mem_q [Depth];

   logic       push, pop, start_frame, bit_end, par_next;
   logic [2:0] nbits_last;

   assign tx_ready_o   = (count_q != CountFull);
   assign tx_o         = tx_q;
   assign tx_busy_o    = (state_q != StIdle);
   assign tx_done_o    = done_q;
   assign fifo_count_o = count_q;

   assign push    = tx_valid_i && tx_ready_o;
   assign bit_end = tick_i && (tick_cnt_q == TickLast);

   // Index of the last data bit; out-of-range widths fall back to 8 bits.
   assign nbits_last = (nbits_i >= 4'd5 && nbits_i <= 4'd8) ? 3'(nbits_i - 4'd1) : 3'd7;

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      nbits_d     = nbits_q;
      par_en_d    = par_en_q;
      par_odd_d   = par_odd_q;
      stop2_d     = stop2_q;
      par_acc_d   = par_acc_q;
      tx_d        = tx_q;
      done_d      = 1'b0;
      start_frame = 1'b0;
      par_next    = par_acc_q ^ shift_q[0];

      if (tick_i && state_q != StIdle) begin
         tick_cnt_d = bit_end ? '0 : tick_cnt_q + TickOne;
      end

      case (state_q)
         StIdle: begin
            if (tick_i && count_q != '0) start_frame = 1'b1;
         end
         StStart: begin
            if (bit_end) begin
               state_d   = StData;
               tx_d      = shift_q[0];
               bit_cnt_d = 3'd0;
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[7:1]};
               par_acc_d = par_next;
               if (bit_cnt_q == nbits_q) begin
                  bit_cnt_d = 3'd0;
                  if (par_en_q) begin
                     state_d = StParity;
                     tx_d    = par_next ^ par_odd_q;
                  end else begin
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = shift_q[1];
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d   = StStop;
               tx_d      = 1'b1;
               bit_cnt_d = 3'd0;
            end
         end
         StStop: begin
            if (bit_end) begin
               if (stop2_q && bit_cnt_q == 3'd0) begin
                  bit_cnt_d = 3'd1;
               end else begin
                  done_d = 1'b1;
                  // A waiting byte starts on this same edge, so frames run back-to-back.
                  if (count_q != '0) begin
                     start_frame = 1'b1;
                  end else begin
                     state_d = StIdle;
                     tx_d    = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase

      if (start_frame) begin
         state_d    = StStart;
         tx_d       = 1'b0;
         shift_d    = mem_q[rptr_q];
         nbits_d    = nbits_last;
         par_en_d   = (parity_i == 2'b01) || (parity_i == 2'b10);
         par_odd_d  = (parity_i == 2'b10);
         stop2_d    = stop_bits_i;
         par_acc_d  = 1'b0;
         tick_cnt_d = '0;
         bit_cnt_d  = 3'd0;
      end
   end

   assign pop = start_frame;

   always_comb begin
      wptr_d  = push ? wptr_q + PtrOne : wptr_q;
      rptr_d  = pop ? rptr_q + PtrOne : rptr_q;
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CountOne;
      end else if (!push && pop) begin
         count_d = count_q - CountOne;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'd0;
         nbits_q    <= 3'd7;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         stop2_q    <= 1'b0;
         par_acc_q  <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         nbits_q    <= nbits_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         stop2_q    <= stop2_d;
         par_acc_q  <= par_acc_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= tx_data_i;
   end

endmodule
